// File: rtl/mp_regfile_pkg.sv
// Shared definitions for the rename-aware register file: parameter defaults
// and the read-result encoding.
package mp_regfile_pkg;
    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREG  = 32;
    localparam int DEF_ROB_W = 4;
    localparam int DEF_NRD   = 2;
    localparam int DEF_NCM   = 2;

    typedef enum logic {
        RD_VALUE = 1'b0,
        RD_TAG   = 1'b1
    } rd_type_e;
endpackage

// File: rtl/mp_regfile_if.sv
// Rename/read/commit bundle between the pipeline (master) and the register file (slave).
interface mp_regfile_if
    import mp_regfile_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREG  = DEF_NREG,
    parameter int ROB_W = DEF_ROB_W,
    parameter int NRD   = DEF_NRD,
    parameter int NCM   = DEF_NCM,
    parameter int RW    = $clog2(NREG)
) ();
    logic                  ready;
    logic                  clear;
    logic [NRD-1:0]        rd_query;
    logic [NRD*RW-1:0]     rd_pos;
    logic                  lock;
    logic [RW-1:0]         lock_rd;
    logic [ROB_W-1:0]      lock_robpos;
    logic [NCM-1:0]        cm_valid;
    logic [NCM*RW-1:0]     cm_rd;
    logic [NCM*ROB_W-1:0]  cm_robpos;
    logic [NCM*XLEN-1:0]   cm_val;
    logic [NRD-1:0]        rd_flag;
    logic [NRD-1:0]        rd_type;
    logic [NRD*XLEN-1:0]   rd_val;
    logic [RW:0]           busy_cnt;

    modport master (
        output ready, clear, rd_query, rd_pos, lock, lock_rd, lock_robpos,
               cm_valid, cm_rd, cm_robpos, cm_val,
        input  rd_flag, rd_type, rd_val, busy_cnt
    );

    modport slave (
        input  ready, clear, rd_query, rd_pos, lock, lock_rd, lock_robpos,
               cm_valid, cm_rd, cm_robpos, cm_val,
        output rd_flag, rd_type, rd_val, busy_cnt
    );
endinterface

// File: rtl/mp_regfile_rdport.sv
// One source read port: returns the committed value, a same-cycle forwarded
// commit value, or the pending ROB tag of the selected register.
module regfile_rdport
    import mp_regfile_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int ROB_W = DEF_ROB_W,
    parameter int NCM   = DEF_NCM
) (
    input  logic                 i_query,
    input  logic                 i_busy,
    input  logic [ROB_W-1:0]     i_qi,
    input  logic [XLEN-1:0]      i_val,
    input  logic [NCM-1:0]       i_cm_valid,
    input  logic [NCM*ROB_W-1:0] i_cm_robpos,
    input  logic [NCM*XLEN-1:0]  i_cm_val,
    output logic                 o_flag,
    output logic                 o_type,
    output logic [XLEN-1:0]      o_val
);
    logic            w_hit;
    logic [XLEN-1:0] w_fwd;
    rd_type_e        w_type;

    // Tags are unique in flight, so at most one commit port can match.
    always_comb begin
        w_hit = 1'b0;
        w_fwd = '0;
        for (int k = 0; k < NCM; k++) begin
            if (i_cm_valid[k] && (i_cm_robpos[k*ROB_W +: ROB_W] == i_qi)) begin
                w_hit = 1'b1;
                w_fwd = i_cm_val[k*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        w_type = RD_VALUE;
        o_val  = '0;
        if (!i_query) begin
            w_type = RD_VALUE;
            o_val  = '0;
        end else if (!i_busy) begin
            o_val = i_val;
        end else if (w_hit) begin
            o_val = w_fwd;
        end else begin
            w_type = RD_TAG;
            o_val  = XLEN'(i_qi);
        end
    end

    assign o_flag = i_query;
    assign o_type = w_type;
endmodule

// File: rtl/mp_regfile.sv
// Architectural register file with rename tags: lock marks a register busy
// under a ROB tag, commits write values and release the matching tag.
module mp_regfile
    import mp_regfile_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREG  = DEF_NREG,
    parameter int ROB_W = DEF_ROB_W,
    parameter int NRD   = DEF_NRD,
    parameter int NCM   = DEF_NCM
) (
    input  logic          clk,
    input  logic          reset,
    mp_regfile_if.slave   bus
);
    localparam int RW = $clog2(NREG);

    logic [XLEN-1:0]  r_val [NREG];
    logic [ROB_W-1:0] r_qi  [NREG];
    logic [NREG-1:0]  r_busy;
    logic [RW:0]      r_busy_cnt;

    logic [XLEN-1:0]  w_val_nxt [NREG];
    logic [ROB_W-1:0] w_qi_nxt  [NREG];
    logic [NREG-1:0]  w_busy_nxt;
    logic [RW:0]      w_cnt_nxt;

    // Ascending k order lets the youngest commit win a duplicate destination,
    // and the lock is applied last so it overrides any busy-clear.
    always_comb begin
        w_val_nxt  = r_val;
        w_qi_nxt   = r_qi;
        w_busy_nxt = r_busy;
        if (bus.clear) begin
            for (int k = 0; k < NCM; k++) begin
                if (bus.cm_valid[k] && (bus.cm_rd[k*RW +: RW] != '0))
                    w_val_nxt[bus.cm_rd[k*RW +: RW]] = bus.cm_val[k*XLEN +: XLEN];
            end
            w_busy_nxt = '0;
            for (int r = 0; r < NREG; r++)
                w_qi_nxt[r] = '0;
        end else if (bus.ready) begin
            for (int k = 0; k < NCM; k++) begin
                if (bus.cm_valid[k] && (bus.cm_rd[k*RW +: RW] != '0)) begin
                    w_val_nxt[bus.cm_rd[k*RW +: RW]] = bus.cm_val[k*XLEN +: XLEN];
                    if (r_qi[bus.cm_rd[k*RW +: RW]] == bus.cm_robpos[k*ROB_W +: ROB_W])
                        w_busy_nxt[bus.cm_rd[k*RW +: RW]] = 1'b0;
                end
            end
            if (bus.lock && (bus.lock_rd != '0)) begin
                w_qi_nxt[bus.lock_rd]   = bus.lock_robpos;
                w_busy_nxt[bus.lock_rd] = 1'b1;
            end
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int r = 0; r < NREG; r++)
            w_cnt_nxt = w_cnt_nxt + {{RW{1'b0}}, w_busy_nxt[r]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                r_val[r] <= '0;
                r_qi[r]  <= '0;
            end
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_val      <= w_val_nxt;
            r_qi       <= w_qi_nxt;
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    assign bus.busy_cnt = r_busy_cnt;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [RW-1:0] w_pos;
        assign w_pos = bus.rd_pos[i*RW +: RW];

        regfile_rdport #(
            .XLEN  (XLEN),
            .ROB_W (ROB_W),
            .NCM   (NCM)
        ) u_rdport (
            .i_query     (bus.rd_query[i]),
            .i_busy      (r_busy[w_pos]),
            .i_qi        (r_qi[w_pos]),
            .i_val       (r_val[w_pos]),
            .i_cm_valid  (bus.cm_valid),
            .i_cm_robpos (bus.cm_robpos),
            .i_cm_val    (bus.cm_val),
            .o_flag      (bus.rd_flag[i]),
            .o_type      (bus.rd_type[i]),
            .o_val       (bus.rd_val[i*XLEN +: XLEN])
        );
    end
endmodule

// File: tb/tb_mp_regfile.sv
// Directed bench for mp_regfile: rename, forwarding, duplicate commits,
// stall, flush and x0 behaviour.
module tb_mp_regfile;
    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int ROB_W = 4;
    localparam int NRD   = 2;
    localparam int NCM   = 2;
    localparam int RW    = 5;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mp_regfile_if #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NRD(NRD), .NCM(NCM)) bus ();

    mp_regfile #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NRD(NRD), .NCM(NCM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.ready       = 1'b1;
        bus.clear       = 1'b0;
        bus.rd_query    = '0;
        bus.rd_pos      = '0;
        bus.lock        = 1'b0;
        bus.lock_rd     = '0;
        bus.lock_robpos = '0;
        bus.cm_valid    = '0;
        bus.cm_rd       = '0;
        bus.cm_robpos   = '0;
        bus.cm_val      = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic query(input int p, input logic [RW-1:0] r);
        bus.rd_query[p]       = 1'b1;
        bus.rd_pos[p*RW +: RW] = r;
    endtask

    task automatic do_lock(input logic [RW-1:0] r, input logic [ROB_W-1:0] tag);
        bus.lock        = 1'b1;
        bus.lock_rd     = r;
        bus.lock_robpos = tag;
    endtask

    task automatic commit(input int k, input logic [RW-1:0] r, input logic [ROB_W-1:0] tag,
                          input logic [XLEN-1:0] v);
        bus.cm_valid[k]               = 1'b1;
        bus.cm_rd[k*RW +: RW]         = r;
        bus.cm_robpos[k*ROB_W +: ROB_W] = tag;
        bus.cm_val[k*XLEN +: XLEN]    = v;
    endtask

    function automatic logic [XLEN+1:0] obs(input int p);
        return {bus.rd_flag[p], bus.rd_type[p], bus.rd_val[p*XLEN +: XLEN]};
    endfunction

    function automatic logic [XLEN+1:0] mk(input logic f, input logic t, input logic [XLEN-1:0] v);
        return {f, t, v};
    endfunction

    task automatic test_reset();
        logic [XLEN+1:0] e;
        reset = 1'b1;
        idle();
        do_lock(5'd9, 4'd7);
        commit(0, 5'd9, 4'd7, 32'h7);
        step();
        step();
        reset = 1'b0;
        idle();
        query(0, 5'd9);
        bus.rd_pos[RW +: RW] = 5'd5;
        #1;
        checks++;
        if (bus.busy_cnt !== 6'd0) begin
            errors++; $display("FAIL reset_cnt act=%0d req=0", bus.busy_cnt);
        end
        e = mk(1'b1, 1'b0, 32'h0); checks++;
        if (obs(0) !== e) begin errors++; $display("FAIL reset_x9 act=%h req=%h", obs(0), e); end
        e = mk(1'b0, 1'b0, 32'h0); checks++;
        if (obs(1) !== e) begin errors++; $display("FAIL reset_noquery act=%h req=%h", obs(1), e); end
    endtask

    task automatic test_lock_fwd();
        logic [XLEN+1:0] e;
        idle();
        do_lock(5'd5, 4'd3);
        query(0, 5'd5);
        #1;
        e = mk(1'b1, 1'b0, 32'h0); checks++;
        if (obs(0) !== e) begin errors++; $display("FAIL lock_invisible act=%h req=%h", obs(0), e); end
        step();
        idle();
        query(0, 5'd5);
        query(1, 5'd5);
        #1;
        e = mk(1'b1, 1'b1, 32'd3); checks++;
        if (obs(0) !== e) begin errors++; $display("FAIL lock_tag act=%h req=%h", obs(0), e); end
        checks++;
        if (bus.busy_cnt !== 6'd1) begin errors++; $display("FAIL lock_cnt act=%0d req=1", bus.busy_cnt); end
        commit(0, 5'd5, 4'd3, 32'hAB);
        #1;
        e = mk(1'b1, 1'b0, 32'hAB); checks++;
        if (obs(0) !== e) begin errors++; $display("FAIL fwd_p0 act=%h req=%h", obs(0), e); end
        checks++;
        if (obs(1) !== e) begin errors++; $display("FAIL fwd_p1 act=%h req=%h", obs(1), e); end
        step();
        idle();
        query(0, 5'd5);
        #1;
        e = mk(1'b1, 1'b0, 32'hAB); checks++;
        if (obs(0) !== e) begin errors++; $display("FAIL commit_val act=%h req=%h", obs(0), e); end
        checks++;
        if (bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL commit_cnt act=%0d req=0", bus.busy_cnt); end
    endtask

    task automatic test_lock_commit_same();
        logic [XLEN+1:0] e;
        idle();
        do_lock(5'd7, 4'd4);
        commit(0, 5'd7, 4'd2, 32'd9);
        step();
        idle();
        query(0, 5'd7);
        #1;
        e = mk(1'b1, 1'b1, 32'd4); checks++;
        if (obs(0) !== e) begin errors++; $display("FAIL same_tag act=%h req=%h", obs(0), e); end
        bus.clear = 1'b1;
        step();
        idle();
        query(0, 5'd7);
        #1;
        e = mk(1'b1, 1'b0, 32'd9); checks++;
        if (obs(0) !== e) begin errors++; $display("FAIL same_val act=%h req=%h", obs(0), e); end
        do_lock(5'd7, 4'd4);
        step();
        idle();
        do_lock(5'd7, 4'd5);
        commit(1, 5'd7, 4'd4, 32'h11);
        step();
        idle();
        query(0, 5'd7);
        #1;
        e = mk(1'b1, 1'b1, 32'd5); checks++;
        if (obs(0) !== e) begin errors++; $display("FAIL lock_prio act=%h req=%h", obs(0), e); end
        checks++;
        if (bus.busy_cnt !== 6'd1) begin errors++; $display("FAIL lock_prio_cnt act=%0d req=1", bus.busy_cnt); end
        bus.clear = 1'b1;
        step();
        idle();
        query(0, 5'd7);
        #1;
        e = mk(1'b1, 1'b0, 32'h11); checks++;
        if (obs(0) !== e) begin errors++; $display("FAIL lock_prio_val act=%h req=%h", obs(0), e); end
    endtask

    task automatic test_dup_commit();
        logic [XLEN+1:0] e;
        idle();
        do_lock(5'd3, 4'd2);
        step();
        idle();
        commit(0, 5'd3, 4'd1, 32'd10);
        commit(1, 5'd3, 4'd2, 32'd20);
        step();
        idle();
        query(0, 5'd3);
        #1;
        e = mk(1'b1, 1'b0, 32'd20); checks++;
        if (obs(0) !== e) begin errors++; $display("FAIL dup_val act=%h req=%h", obs(0), e); end
        checks++;
        if (bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL dup_cnt act=%0d req=0", bus.busy_cnt); end
    endtask

    task automatic test_stall();
        logic [XLEN+1:0] e;
        idle();
        do_lock(5'd1, 4'd1);
        step();
        idle();
        do_lock(5'd2, 4'd2);
        step();
        idle();
        bus.ready = 1'b0;
        commit(0, 5'd1, 4'd1, 32'h77);
        do_lock(5'd9, 4'd7);
        step();
        idle();
        query(0, 5'd1);
        query(1, 5'd9);
        #1;
        checks++;
        if (bus.busy_cnt !== 6'd2) begin errors++; $display("FAIL stall_cnt act=%0d req=2", bus.busy_cnt); end
        e = mk(1'b1, 1'b1, 32'd1); checks++;
        if (obs(0) !== e) begin errors++; $display("FAIL stall_x1 act=%h req=%h", obs(0), e); end
        e = mk(1'b1, 1'b0, 32'd0); checks++;
        if (obs(1) !== e) begin errors++; $display("FAIL stall_x9 act=%h req=%h", obs(1), e); end
        bus.rd_query[1]      = 1'b0;
        bus.rd_pos[RW +: RW] = 5'd1;
        #1;
        e = mk(1'b0, 1'b0, 32'd0); checks++;
        if (obs(1) !== e) begin errors++; $display("FAIL noquery_busy act=%h req=%h", obs(1), e); end
    endtask

    task automatic test_clear();
        logic [XLEN+1:0] e;
        idle();
        bus.ready = 1'b0;
        bus.clear = 1'b1;
        commit(0, 5'd4, 4'd0, 32'h55);
        do_lock(5'd6, 4'd6);
        step();
        idle();
        query(0, 5'd4);
        query(1, 5'd6);
        #1;
        checks++;
        if (bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL clear_cnt act=%0d req=0", bus.busy_cnt); end
        e = mk(1'b1, 1'b0, 32'h55); checks++;
        if (obs(0) !== e) begin errors++; $display("FAIL clear_x4 act=%h req=%h", obs(0), e); end
        e = mk(1'b1, 1'b0, 32'h0); checks++;
        if (obs(1) !== e) begin errors++; $display("FAIL clear_x6 act=%h req=%h", obs(1), e); end
        bus.rd_pos[0 +: RW] = 5'd1;
        #1;
        checks++;
        if (obs(0) !== e) begin errors++; $display("FAIL clear_x1 act=%h req=%h", obs(0), e); end
    endtask

    task automatic test_x0();
        logic [XLEN+1:0] e;
        idle();
        do_lock(5'd0, 4'd9);
        commit(0, 5'd0, 4'd0, 32'h123);
        query(0, 5'd0);
        #1;
        e = mk(1'b1, 1'b0, 32'h0); checks++;
        if (obs(0) !== e) begin errors++; $display("FAIL x0_pre act=%h req=%h", obs(0), e); end
        step();
        idle();
        query(0, 5'd0);
        #1;
        checks++;
        if (obs(0) !== e) begin errors++; $display("FAIL x0_post act=%h req=%h", obs(0), e); end
        checks++;
        if (bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL x0_cnt act=%0d req=0", bus.busy_cnt); end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_lock_fwd();
        test_lock_commit_same();
        test_dup_commit();
        test_stall();
        test_clear();
        test_x0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
